// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and initiator-side controller for the execute-stage
// multiply/divide unit.
//   - MTHI/MTLO write HI/LO in the accept cycle, with no stall.
//   - MULT/MULTU use a registered 2-cycle local multiply.
//   - DIV/DIVU with rt==0 resolve locally: HI=rs, LO=all ones.
//   - Other DIV/DIVU ops send unsigned magnitudes to the iterative engine and
//     sign-correct its result on return.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   req_valid/req_op/req_a/b    request from EX
//   busy                        stall to EX, from accept through write-back
//   hi, lo                      architectural HI/LO
//   div_valid/div_a/div_b       start pulse and operand magnitudes to engine
//   div_done/div_c              engine finish flag and {rem, quot} result
module muldiv_ctrl #(
   parameter int unsigned DIV_CYCLES = 33
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_valid,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_done,
   input  logic [63:0] div_c
);

   // The sequencing is driven only by div_done. DIV_CYCLES is kept so the
   // engine latency is documented next to the controller.
   if (DIV_CYCLES < 1) begin : g_bad_div_cycles
      $error("DIV_CYCLES must be positive");
   end

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [2:0] {IDLE, FIN1, DIV_ISSUE, DIV_WAIT, DIV_TAKE} state_t;

   state_t      state, state_nxt;
   logic        accept, is_muldiv;
   logic [31:0] op_a, op_b;        // multiply operands, or rs for divide-by-zero
   logic        mul_sgn, fin_div;  // FIN1 flavour: signed mult / div-by-zero
   logic        q_neg, r_neg;
   logic        sdiv;
   logic [63:0] a_ext, b_ext, prod;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction

   assign accept    = req_valid && (state == IDLE) && (req_op != 3'd0) && (req_op != 3'd7);
   assign is_muldiv = (req_op >= OP_MULT) && (req_op <= OP_DIVU);
   assign sdiv      = (req_op == OP_DIV);

   // The upper 32 bits of a 64x64 product of sign-extended operands give the
   // signed high word. With zero extension, the same product is the unsigned one.
   assign a_ext = {{32{mul_sgn & op_a[31]}}, op_a};
   assign b_ext = {{32{mul_sgn & op_b[31]}}, op_b};
   assign prod  = a_ext * b_ext;

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && is_muldiv) begin
               if ((req_op == OP_DIV || req_op == OP_DIVU) && req_b != 32'd0)
                  state_nxt = DIV_ISSUE;
               else
                  state_nxt = FIN1;
            end
         end
         FIN1:      state_nxt = IDLE;
         DIV_ISSUE: state_nxt = DIV_WAIT;
         // div_done is also high while the engine idles. It is only trusted here.
         DIV_WAIT:  if (div_done) state_nxt = DIV_TAKE;
         DIV_TAKE:  state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy      = (state != IDLE) || (accept && is_muldiv);
      div_valid = (state == DIV_ISSUE);
   end

   // Datapath: operand latches and HI/LO
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi      <= '0;
         lo      <= '0;
         op_a    <= '0;
         op_b    <= '0;
         mul_sgn <= 1'b0;
         fin_div <= 1'b0;
         div_a   <= '0;
         div_b   <= '0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         if (accept) begin
            case (req_op)
               OP_MTHI: hi <= req_a;
               OP_MTLO: lo <= req_a;
               OP_MULT, OP_MULTU: begin
                  op_a    <= req_a;
                  op_b    <= req_b;
                  mul_sgn <= (req_op == OP_MULT);
                  fin_div <= 1'b0;
               end
               OP_DIV, OP_DIVU: begin
                  if (req_b == 32'd0) begin
                     op_a    <= req_a;
                     fin_div <= 1'b1;
                  end else begin
                     // INT_MIN negates to itself. Read as unsigned, it is the
                     // correct magnitude.
                     div_a <= (sdiv && req_a[31]) ? neg32(req_a) : req_a;
                     div_b <= (sdiv && req_b[31]) ? neg32(req_b) : req_b;
                     q_neg <= sdiv && (req_a[31] ^ req_b[31]);
                     r_neg <= sdiv && req_a[31];
                  end
               end
               default: ;
            endcase
         end
         if (state == FIN1) begin
            if (fin_div) begin
               hi <= op_a;
               lo <= 32'hFFFF_FFFF;
            end else begin
               {hi, lo} <= prod;
            end
         end
         // div_c is valid for this one cycle only.
         if (state == DIV_TAKE) begin
            lo <= q_neg ? neg32(div_c[31:0])  : div_c[31:0];
            hi <= r_neg ? neg32(div_c[63:32]) : div_c[63:32];
         end
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
   localparam int DIV_CYCLES = 33;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        busy;
   logic [31:0] hi, lo;
   logic        div_valid;
   logic [31:0] div_a, div_b;
   logic        div_done;
   logic [63:0] div_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   muldiv_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .resetn(resetn),
      .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .busy(busy), .hi(hi), .lo(lo),
      .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
      .div_done(div_done), .div_c(div_c)
   );

   // ---------------- engine model ----------------
   // cnt counts DOING cycles 1..DIV_CYCLES. done is high when idle and in the last
   // DOING cycle. The result shows on div_c for exactly one cycle afterwards.
   int          e_cnt;
   logic [31:0] e_a, e_b;
   logic        e_res;

   assign div_done = (e_cnt == 0) || (e_cnt == DIV_CYCLES);
   assign div_c    = e_res ? {e_a % e_b, e_a / e_b} : 64'hDEAD_BEEF_DEAD_BEEF;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         e_cnt <= 0;
         e_res <= 1'b0;
         e_a   <= '0;
         e_b   <= 32'd1;
      end else begin
         e_res <= (e_cnt == DIV_CYCLES);
         if (e_cnt == 0) begin
            if (div_valid) begin
               e_cnt <= 1;
               e_a   <= div_a;
               e_b   <= div_b;
            end
         end else if (e_cnt == DIV_CYCLES) begin
            e_cnt <= 0;
         end else begin
            e_cnt <= e_cnt + 1;
         end
      end
   end

   // Operands must stay stable for the whole run.
   always @(negedge clk) begin
      if (resetn && e_cnt != 0) begin
         total++;
         if (div_b !== e_b || div_a !== e_a) begin
            bad++;
            $display("FAIL engine_operand_stable: div_a=%h div_b=%h required %h %h", div_a, div_b, e_a, e_b);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a request at a negedge and sample 1 time unit later each cycle.
   // Busy cycles are counted until busy first drops.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int bcyc, output int pulses, output int pulse_at,
                        output logic [31:0] da, output logic [31:0] db);
      bit done_ok = 1'b0;
      bcyc = 0; pulses = 0; pulse_at = -1; da = '0; db = '0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      for (int t = 0; t < 100; t++) begin
         #1;
         if (div_valid) begin
            pulses++; pulse_at = t; da = div_a; db = div_b;
         end
         if (!busy) begin
            done_ok = 1'b1;
            break;
         end
         bcyc++;
         @(negedge clk);
         req_valid = 1'b0;
      end
      if (!done_ok) begin
         total++; bad++;
         $display("FAIL op_timeout: busy still %b after 100 cycles, required 0", busy);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [31:0] exp_hi, exp_lo;
      int          exp_busy;
      int          exp_pulses;
      logic [31:0] exp_da, exp_db;
   } vec_t;

   localparam int NV = 11;
   localparam int DB = DIV_CYCLES + 3;
   vec_t vecs [NV];

   int          bcyc, pulses, pulse_at;
   logic [31:0] da, db;

   initial begin
      vecs[0]  = '{3'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 2,  0, 0, 0};
      vecs[1]  = '{3'd2, 32'hFFFF_FFFD, 32'd5,        32'h4,         32'hFFFF_FFF1, 2,  0, 0, 0};
      vecs[2]  = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        DB, 1, 32'd100, 32'd7};
      vecs[3]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DB, 1, 32'd7, 32'd2};
      vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DB, 1, 32'd7, 32'd2};
      vecs[5]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DB, 1, 32'h8000_0000, 32'd1};
      vecs[6]  = '{3'd3, 32'd42,        32'd0,        32'd42,        32'hFFFF_FFFF, 2,  0, 0, 0};
      vecs[7]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'd1,         32'h7FFF_FFFC, DB, 1, 32'hFFFF_FFF9, 32'd2};
      vecs[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,       2,  0, 0, 0};
      vecs[9]  = '{3'd7, 32'h1111_1111, 32'd3,        32'h4000_0000, 32'd0,         0,  0, 0, 0};
      vecs[10] = '{3'd4, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 2,  0, 0, 0};

      resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_div_valid", {31'd0, div_valid}, 32'd0);
      chk("reset_div_a", div_a, 32'd0);

      // Back-to-back MTHI/MTLO: no stall, each written by the next cycle.
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd5; req_a = 32'h1234_5678; req_b = '0;
      #1 chk("mthi_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      req_op = 3'd6; req_a = 32'hCAFE_F00D;
      #1 chk("mthi_hi", hi, 32'h1234_5678);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      #1 chk("mtlo_lo", lo, 32'hCAFE_F00D);
      chk("mtlo_hi_kept", hi, 32'h1234_5678);

      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, bcyc, pulses, pulse_at, da, db);
         chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
         chk($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].exp_busy);
         chk($sformatf("v%0d_div_pulses", i), pulses, vecs[i].exp_pulses);
         if (vecs[i].exp_pulses != 0) begin
            chk($sformatf("v%0d_pulse_at", i), pulse_at, 32'd1);
            chk($sformatf("v%0d_div_a", i), da, vecs[i].exp_da);
            chk($sformatf("v%0d_div_b", i), db, vecs[i].exp_db);
         end
      end

      // Reset in the middle of a divide, then a clean divide afterwards.
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3;
      repeat (10) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      resetn = 1'b0;
      #1 chk("midreset_busy_before", {31'd0, busy}, 32'd1);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("midreset_busy", {31'd0, busy}, 32'd0);
      chk("midreset_hi", hi, 32'd0);
      chk("midreset_lo", lo, 32'd0);
      chk("midreset_div_a", div_a, 32'd0);
      chk("midreset_div_b", div_b, 32'd0);
      do_op(3'd4, 32'd9, 32'd4, bcyc, pulses, pulse_at, da, db);
      chk("post_reset_busy_cycles", bcyc, DB);
      chk("post_reset_pulses", pulses, 32'd1);
      chk("post_reset_lo", lo, 32'd2);
      chk("post_reset_hi", hi, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Initiator-side controller for the iterative unsigned divider engine in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and owns the architectural HI/LO registers.
- Computes multiplies locally (registered, 2 cycles). Divides are issued to the engine as unsigned magnitudes, then sign-corrected on return.
- Drives the pipeline stall (`busy`) for the full duration of every multi-cycle operation.

Parameters:
- DIV_CYCLES, 33: engine DOING-cycle count; informational only, used by bench checks and not by RTL.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request present from EX
- req_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (ignored)
- req_a  in  32  rs operand (dividend/multiplicand; MTHI/MTLO data)
- req_b  in  32  rt operand (divisor/multiplier)
- busy  out  1  stall EX; high from accept cycle through write-back cycle
- hi  out  32  HI register
- lo  out  32  LO register
- div_valid  out  1  single-cycle start pulse to engine
- div_a  out  32  unsigned dividend magnitude, held stable from issue until result taken
- div_b  out  32  unsigned divisor magnitude, held stable likewise
- div_done  in  1  engine idle / finishing indication
- div_c  in  64  engine result {remainder[63:32], quotient[31:0]}

Behaviour:
- Engine contract:
  - Engine samples div_a every idle cycle; it starts on div_valid.
  - div_done is high whenever the engine is idle, including before issue, so it is only meaningful in DIV_WAIT.
  - div_done rises in the last of 33 DOING cycles.
  - div_c holds the final result in the following cycle only.
  - div_b must stay stable for the entire run.
  - Engine shares resetn.
- States: IDLE, FIN1, DIV_ISSUE, DIV_WAIT, DIV_TAKE.
- accept = req_valid & state==IDLE & req_op in {1..6}. Requests while not IDLE are ignored; EX holds them because busy is high.
- busy = (state != IDLE) | (accept & req_op in {1..4}). MTHI/MTLO never raise busy.
- MTHI/MTLO:
  - On accept, hi (resp. lo) <= req_a at the end of the same cycle.
  - State stays IDLE.
- MULT/MULTU:
  - On accept, latch operands and signedness; go to FIN1.
  - In FIN1, {hi,lo} <= 64-bit product: signed for MULT, unsigned for MULTU. Then go to IDLE.
  - busy high 2 cycles.
- DIV/DIVU with req_b == 0:
  - Engine is not used; go to FIN1.
  - In FIN1, hi <= req_a (latched), lo <= 32'hFFFF_FFFF.
  - busy high 2 cycles.
- DIV/DIVU with req_b != 0, cycle-by-cycle (T0 = accept):
  - T0: latch div_a/div_b magnitudes. For DIV, negate negative operands; for DIVU, pass operands through. Also latch q_neg = sign(a)^sign(b) and r_neg = sign(a), both 0 for DIVU. Next state DIV_ISSUE.
  - T1 (DIV_ISSUE): div_valid=1, then go to DIV_WAIT.
  - DIV_WAIT: stay until div_done=1, then go to DIV_TAKE.
  - DIV_TAKE: lo <= q_neg ? -div_c[31:0] : div_c[31:0]; hi <= r_neg ? -div_c[63:32] : div_c[63:32]. Then go to IDLE.
  - Nominal: done at T34, take at T35, busy high T0..T35 (36 cycles).
- Arithmetic: all negation is 32-bit two's complement, so INT_MIN magnitude is 0x8000_0000 unsigned. INT_MIN / -1 gives lo=0x8000_0000, hi=0.
- div_valid is never high outside DIV_ISSUE.
- div_a/div_b hold their latched values in every non-IDLE state.
- Reset (any cycle, including mid-divide): state=IDLE, hi=0, lo=0, busy=0, div_valid=0, operand latches=0. The first request after reset is accepted normally.

Test Plan:
- MTHI 0x1234_5678 then MTLO 0xCAFE_F00D on consecutive cycles -> hi/lo updated the cycle after each; busy never high.
- MULT a=-3 (0xFFFF_FFFD), b=5 -> busy 2 cycles; hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. MULTU same operands -> hi=0x4, lo=0xFFFF_FFF1.
- DIVU 100/7 -> one div_valid pulse at T1; busy exactly T0..T35; lo=14, hi=2.
- DIV 7/-2 -> lo=0xFFFF_FFFD, hi=1. DIV -7/2 -> lo=-3, hi=0xFFFF_FFFF. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIV 42/0 -> no div_valid; busy 2 cycles; hi=42, lo=0xFFFF_FFFF.
- DIVU 1000/3 with resetn low at T10 -> next cycle busy=0, hi=lo=0. A new DIVU 9/4 then completes in 36 cycles with lo=2, hi=1.
